risc16_core: RTL and testbench

Single-cycle 16-bit RiSC-16 processor core. Each rising clock edge completes one instruction: fetch, decode, register read, ALU, data-memory access and writeback. Instruction memory is external; the core drives a word address on `pc` and reads the 16-bit word back combinationally on `instruction`. The core holds the eight-entry register file and a private word-addressed data memory.

---
 rtl/risc16_core.sv | 119 +++++++++++
 tb/tb_risc16_core.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/risc16_core.sv
// rtl/risc16_core.sv - single-cycle 16-bit RiSC-16 processor core
//
// Every rising clock edge retires one instruction. Fetch, decode, register
// read, ALU, data-memory access and writeback all complete in that cycle.
//
// Ports:
//   clk          sole clock, all state updates on the rising edge
//   rst          asynchronous active-high reset (pc and R1-R7 cleared)
//   instruction  instruction word at address pc, combinational from outside
//   pc           program counter (word address), driven from a register
//
// Parameter:
//   p_DATA_MEM_SIZE  words of internal data memory, power of two
module risc16_core #(
  parameter int p_DATA_MEM_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instruction,
  output logic [15:0] pc
);

  localparam int ADDR_W = $clog2(p_DATA_MEM_SIZE);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  logic [15:0] rf [0:7];
  logic [15:0] dmem [0:p_DATA_MEM_SIZE-1];

  logic [2:0]  opcode;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  rc;
  logic [15:0] simm;
  logic [9:0]  imm10;

  logic [15:0] ra_val;
  logic [15:0] rb_val;
  logic [15:0] rc_val;
  logic [15:0] mem_sum;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0] pc_inc;

  logic        rf_we;
  logic [15:0] rf_wdata;
  logic        mem_we;
  logic [15:0] pc_next;

  assign opcode = instruction[15:13];
  assign ra     = instruction[12:10];
  assign rb     = instruction[9:7];
  assign rc     = instruction[2:0];
  assign simm   = {{9{instruction[6]}}, instruction[6:0]};
  assign imm10  = instruction[9:0];

  // R0 is hardwired to zero on read; rf[0] is never written.
  assign ra_val = (ra == 3'd0) ? 16'h0000 : rf[ra];
  assign rb_val = (rb == 3'd0) ? 16'h0000 : rf[rb];
  assign rc_val = (rc == 3'd0) ? 16'h0000 : rf[rc];

  assign mem_sum  = rb_val + simm;
  // Only the low address bits index the memory, so out-of-range addresses wrap.
  assign mem_addr = mem_sum[ADDR_W-1:0];
  assign pc_inc   = pc + 16'd1;

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = 16'h0000;
    mem_we   = 1'b0;
    pc_next  = pc_inc;
    case (opcode)
      OP_ADD:  begin rf_we = 1'b1; rf_wdata = rb_val + rc_val; end
      OP_ADDI: begin rf_we = 1'b1; rf_wdata = rb_val + simm; end
      OP_NAND: begin rf_we = 1'b1; rf_wdata = ~(rb_val & rc_val); end
      OP_LUI:  begin rf_we = 1'b1; rf_wdata = {imm10, 6'b000000}; end
      OP_SW:   mem_we = 1'b1;
      OP_LW:   begin rf_we = 1'b1; rf_wdata = dmem[mem_addr]; end
      OP_BEQ:  if (ra_val == rb_val) pc_next = pc_inc + simm;
      OP_JALR: begin
        // rB was sampled before the link write, so JALR rX,rX jumps to the old value.
        rf_we    = 1'b1;
        rf_wdata = pc_inc;
        pc_next  = rb_val;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 16'h0000;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
    end else if (rf_we && (ra != 3'd0)) begin
      rf[ra] <= rf_wdata;
    end
  end

  // Data memory is not reset; writes are suppressed while rst is held.
  always_ff @(posedge clk) begin
    if (!rst && mem_we) begin
      dmem[mem_addr] <= ra_val;
    end
  end

endmodule

// File: tb/tb_risc16_core.sv
// tb/tb_risc16_core.sv - directed self-checking bench for risc16_core
module tb_risc16_core;

  logic        clk;
  logic        rst;
  logic [15:0] instruction;
  logic [15:0] pc;

  logic [15:0] imem [0:63];

  int total;
  int bad;

  risc16_core #(.p_DATA_MEM_SIZE(1024)) dut (
    .clk         (clk),
    .rst         (rst),
    .instruction (instruction),
    .pc          (pc)
  );

  assign instruction = imem[pc[5:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rrr(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input logic [2:0] c);
    return {op, a, b, 4'b0000, c};
  endfunction

  function automatic logic [15:0] rri(input logic [2:0] op, input logic [2:0] a,
                                      input logic [2:0] b, input int imm);
    logic [6:0] s;
    s = imm[6:0];
    return {op, a, b, s};
  endfunction

  function automatic logic [15:0] ri(input logic [2:0] op, input logic [2:0] a,
                                     input logic [9:0] imm);
    return {op, a, imm};
  endfunction

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 16'h0000;
  endtask

  // Hold reset across one clock edge, then release it just after a falling edge.
  task automatic reset_cpu();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clear_imem();

    // ADDI / ADD with pc progression
    imem[0] = rri(3'b001, 3'd1, 3'd0, 5);
    imem[1] = rri(3'b001, 3'd2, 3'd0, -3);
    imem[2] = rrr(3'b000, 3'd3, 3'd1, 3'd2);
    reset_cpu();
    check_val("reset_pc", pc, 16'd0);
    check_val("reset_r1", dut.rf[1], 16'd0);
    step(1); check_val("pc1", pc, 16'd1);
    step(1); check_val("pc2", pc, 16'd2);
    step(1); check_val("pc3", pc, 16'd3);
    check_val("addi_r1", dut.rf[1], 16'd5);
    check_val("addi_neg_r2", dut.rf[2], 16'hFFFD);
    check_val("add_r3", dut.rf[3], 16'd2);

    // LUI / ADDI / NAND
    clear_imem();
    imem[0] = ri(3'b011, 3'd1, 10'h3FF);
    imem[1] = rri(3'b001, 3'd1, 3'd1, 63);
    imem[2] = rrr(3'b010, 3'd2, 3'd1, 3'd1);
    reset_cpu();
    step(1); check_val("lui_r1", dut.rf[1], 16'hFFC0);
    step(1); check_val("addi_r1_ffff", dut.rf[1], 16'hFFFF);
    step(1); check_val("nand_r2", dut.rf[2], 16'h0000);

    // SW / LW and address wrap
    clear_imem();
    imem[0] = rri(3'b001, 3'd1, 3'd0, 7);
    imem[1] = rri(3'b100, 3'd1, 3'd0, 10);
    imem[2] = rri(3'b101, 3'd2, 3'd0, 10);
    imem[3] = ri(3'b011, 3'd4, 10'd16);
    imem[4] = rri(3'b001, 3'd5, 3'd0, 11);
    imem[5] = rri(3'b100, 3'd5, 3'd4, 10);
    imem[6] = rri(3'b101, 3'd6, 3'd0, 10);
    reset_cpu();
    step(3); check_val("lw_r2", dut.rf[2], 16'd7);
    step(1); check_val("lui_1024", dut.rf[4], 16'd1024);
    step(3); check_val("lw_wrap_r6", dut.rf[6], 16'd11);

    // R0 write discard
    clear_imem();
    imem[0] = rri(3'b001, 3'd1, 3'd0, 1);
    imem[1] = rri(3'b001, 3'd0, 3'd0, 9);
    imem[2] = rrr(3'b000, 3'd1, 3'd0, 3'd0);
    reset_cpu();
    step(1); check_val("r1_pre", dut.rf[1], 16'd1);
    step(2); check_val("r0_discard_r1", dut.rf[1], 16'd0);

    // BEQ taken, backward
    clear_imem();
    imem[0] = rri(3'b001, 3'd1, 3'd0, 6);
    imem[1] = rri(3'b001, 3'd2, 3'd0, 6);
    imem[4] = rri(3'b110, 3'd1, 3'd2, -2);
    reset_cpu();
    step(4); check_val("beq_at4", pc, 16'd4);
    step(1); check_val("beq_taken", pc, 16'd3);

    // BEQ not taken
    clear_imem();
    imem[0] = rri(3'b001, 3'd1, 3'd0, 6);
    imem[1] = rri(3'b001, 3'd2, 3'd0, 7);
    imem[4] = rri(3'b110, 3'd1, 3'd2, -2);
    reset_cpu();
    step(5); check_val("beq_not_taken", pc, 16'd5);

    // JALR, then JALR with rA == rB, then asynchronous reset aborting an instruction
    clear_imem();
    imem[0]  = rri(3'b001, 3'd2, 3'd0, 20);
    imem[8]  = rri(3'b111, 3'd1, 3'd2, 0);
    imem[20] = rri(3'b001, 3'd3, 3'd0, 30);
    imem[21] = rri(3'b111, 3'd3, 3'd3, 0);
    imem[30] = rri(3'b001, 3'd1, 3'd0, 33);
    reset_cpu();
    step(9);
    check_val("jalr_link_r1", dut.rf[1], 16'd9);
    check_val("jalr_pc", pc, 16'd20);
    step(2);
    check_val("jalr_same_pc", pc, 16'd30);
    check_val("jalr_same_r3", dut.rf[3], 16'd22);
    #2 rst = 1'b1;
    #1;
    check_val("async_rst_pc", pc, 16'd0);
    check_val("async_rst_r1", dut.rf[1], 16'd0);
    check_val("async_rst_r3", dut.rf[3], 16'd0);
    step(1);
    check_val("rst_hold_pc", pc, 16'd0);
    check_val("rst_hold_r1", dut.rf[1], 16'd0);
    rst = 1'b0;
    step(1);
    check_val("after_rst_pc", pc, 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
